// File: rtl/chunked_addsub_pkg.sv
// Shared types and helpers for the chunked multi-cycle adder/subtractor.
package chunked_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Chunk index width; a single-chunk build still needs one bit.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/chunked_addsub_chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder; the single adder shared by all chunks.
module chunk_adder #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);

   always_comb begin
      logic c;
      sum = '0;
      c   = cin;
      for (int i = 0; i < CHUNK; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock through one shared adder.
// Optional zero-result flag enabled by defining CHUNKED_ADDSUB_ZERO_FLAG_EN.
module chunked_addsub #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
`ifdef CHUNKED_ADDSUB_ZERO_FLAG_EN
   ,
   output logic             zero
`endif
);

   import chunked_addsub_pkg::*;

   localparam int              NCHUNK   = WIDTH / CHUNK;
   localparam int              IDXW     = idx_width(NCHUNK);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   state_t           r_state;
   state_t           w_next;
   logic [IDXW-1:0]  r_idx;
   logic             r_carry;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;
   logic [CHUNK-1:0] w_ca;
   logic [CHUNK-1:0] w_cb;
   logic [CHUNK-1:0] w_cs;
   logic             w_cc;
   logic             w_accept;
   logic             w_last;
   logic             w_run;

   assign w_run    = (r_state == RUN);
   assign w_accept = start && !w_run;
   assign w_last   = (r_idx == LAST_IDX);
   assign w_ca     = r_a[r_idx*CHUNK +: CHUNK];
   assign w_cb     = r_b[r_idx*CHUNK +: CHUNK];

   chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
      .a    (w_ca),
      .b    (w_cb),
      .cin  (r_carry),
      .sum  (w_cs),
      .cout (w_cc)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = RUN;
         RUN:     if (w_last) w_next = DONE;
         DONE:    w_next = start ? RUN : IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Operands are pure data: captured on accept, never cleared.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_a <= a;
         r_b <= sub ? ~b : b;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         r_idx   <= '0;
         r_carry <= sub | cin;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_run) begin
         r_sum[r_idx*CHUNK +: CHUNK] <= w_cs;
         r_carry <= w_cc;
         r_idx   <= w_last ? '0 : r_idx + 1'b1;
         // On the last chunk the chunk MSBs are the operand/result MSBs.
         if (w_last) begin
            r_cout <= w_cc;
            r_ovf  <= (w_ca[CHUNK-1] == w_cb[CHUNK-1]) && (w_cs[CHUNK-1] != w_ca[CHUNK-1]);
         end
      end
   end

`ifdef CHUNKED_ADDSUB_ZERO_FLAG_EN
   logic r_nz;
   logic r_zero;

   always_ff @(posedge clk) begin
      if (reset || w_accept) begin
         r_nz   <= 1'b0;
         r_zero <= 1'b0;
      end else if (w_run) begin
         r_nz <= r_nz | (|w_cs);
         if (w_last) r_zero <= ~(r_nz | (|w_cs));
      end
   end

   assign zero = r_zero;
`endif

   assign busy     = w_run;
   assign done     = (r_state == DONE);
   assign sum      = r_sum;
   assign cout     = r_cout;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_chunked_addsub.sv
// Self-checking bench for chunked_addsub: directed table, handshake corner cases,
// and random operations checked against an arithmetic reference model.
module tb_chunked_addsub;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, sub, cin;
   logic [31:0] a, b;
   logic        busy, done, cout, overflow;
   logic [31:0] sum;

   logic        start1, sub1, cin1;
   logic [31:0] a1, b1;
   logic        busy1, done1, cout1, ovf1;
   logic [31:0] sum1;

`ifdef CHUNKED_ADDSUB_ZERO_FLAG_EN
   logic        zero, zero1;
`endif

   int total = 0;
   int bad   = 0;

   chunked_addsub #(.WIDTH(32), .CHUNK(8)) u_dut (
      .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
`ifdef CHUNKED_ADDSUB_ZERO_FLAG_EN
      , .zero(zero)
`endif
   );

   chunked_addsub #(.WIDTH(32), .CHUNK(32)) u_dut_wide (
      .clk(clk), .reset(reset), .start(start1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
`ifdef CHUNKED_ADDSUB_ZERO_FLAG_EN
      , .zero(zero1)
`endif
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        ci;
      logic        s;
      logic [31:0] es;
      logic        ec;
      logic        eo;
   } vec_t;

   vec_t tv [8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Reference: unsigned carry and signed overflow judged from exact wide results.
   function automatic void model(input logic [31:0] ia, ib, input logic ici, is,
                                 output logic [31:0] rs, output logic rc, ro);
      longint ua, ub, ur, sa, sb, sr;
      ua = longint'({32'h0, ia});
      ub = longint'({32'h0, ib});
      sa = longint'($signed(ia));
      sb = longint'($signed(ib));
      if (is) begin
         ur = ua - ub;
         rc = (ua >= ub);
         sr = sa - sb;
      end else begin
         ur = ua + ub + longint'(ici);
         rc = (ur >= 64'sh1_0000_0000);
         sr = sa + sb + longint'(ici);
      end
      rs = ur[31:0];
      ro = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
   endfunction

   // Drives one request just after an edge, then checks latency, busy window and results.
   task automatic run_op(input string nm, input logic [31:0] ia, ib, input logic ici, is,
                         input logic [31:0] es, input logic ec, eo);
      int n, bc;
      a = ia; b = ib; cin = ici; sub = is; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({nm, "_clr"}, {62'b0, cout, overflow}, 64'd0);
      n = 0; bc = 0;
      while (!done && n < 20) begin
         if (busy) bc++;
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_lat"}, 64'(n), 64'd4);
      chk({nm, "_busycyc"}, 64'(bc), 64'd4);
      chk({nm, "_busy_at_done"}, 64'(busy), 64'd0);
      chk({nm, "_sum"}, 64'(sum), 64'(es));
      chk({nm, "_cout"}, 64'(cout), 64'(ec));
      chk({nm, "_ovf"}, 64'(overflow), 64'(eo));
`ifdef CHUNKED_ADDSUB_ZERO_FLAG_EN
      chk({nm, "_zero"}, 64'(zero), 64'(es == 32'h0));
`endif
   endtask

   initial begin
      int n;
      logic [31:0] ra, rb, ms;
      logic        rci, rs, mc, mo;

      tv[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
      tv[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      tv[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b0};
      tv[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      tv[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
      tv[5] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      tv[6] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      tv[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

      reset = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
      start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_sum", 64'(sum), 64'd0);
      chk("rst_cout_ovf", {62'b0, cout, overflow}, 64'd0);
`ifdef CHUNKED_ADDSUB_ZERO_FLAG_EN
      chk("rst_zero", 64'(zero), 64'd0);
`endif
      reset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_op($sformatf("vec%0d", i), tv[i].a, tv[i].b, tv[i].ci, tv[i].s,
                tv[i].es, tv[i].ec, tv[i].eo);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_pulse", i), 64'(done), 64'd0);
      end

      // Back-to-back: second request held high during the DONE cycle.
      run_op("b2b_first", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      run_op("b2b_second", 32'd7, 32'd5, 1'b0, 1'b1, 32'd2, 1'b1, 1'b0);
      @(posedge clk); #1;

      // Start while busy is ignored.
      a = 32'h100; b = 32'h200; cin = 1'b0; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      a = 32'hDEAD_0000; b = 32'h1111; sub = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!done && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("ign_lat", 64'(n), 64'd2);
      chk("ign_sum", 64'(sum), 64'h300);
      chk("ign_cout", 64'(cout), 64'd0);
      @(posedge clk); #1;

      // Reset mid-operation aborts without a done pulse.
      a = 32'h0000_00FF; b = 32'h1; cin = 1'b0; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_sum", 64'(sum), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      n = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (done) n++;
      end
      chk("abort_nodone", 64'(n), 64'd0);
      run_op("after_abort", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);
      @(posedge clk); #1;

      // Single-chunk instance finishes in one RUN cycle.
      a1 = 32'd10; b1 = 32'd20; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      n = 0;
      while (!done1 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk("wide_lat", 64'(n), 64'd1);
      chk("wide_sum", 64'(sum1), 64'd30);
      chk("wide_cout", 64'(cout1), 64'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 40; i++) begin
         ra  = $urandom;
         rb  = $urandom;
         rci = 1'($urandom_range(0, 1));
         rs  = 1'($urandom_range(0, 1));
         if (i % 5 == 0) rb = rs ? ra : ~ra;
         if (i % 7 == 0) ra = {1'b0, ra[30:0]} | 32'h7FFF_0000;
         model(ra, rb, rci, rs, ms, mc, mo);
         run_op($sformatf("rnd%0d", i), ra, rb, rci, rs, ms, mc, mo);
         if (i % 3 == 0) begin
            @(posedge clk); #1;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
